// File: rtl/exmem_pkg.sv
// Shared encodings and default widths for the EX/MEM pipeline boundary.
package exmem_pkg;

    localparam int DATAWIDTH_DEF = 32;
    localparam int REGINDEX_DEF  = 5;
    localparam int WBSEL_W       = 2;
    localparam int RSEL_W        = 3;
    localparam int WSEL_W        = 2;

    typedef enum logic [WBSEL_W-1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wbsel_e;

    typedef enum logic [RSEL_W-1:0] {
        RS_LB  = 3'd0,
        RS_LH  = 3'd1,
        RS_LW  = 3'd2,
        RS_LBU = 3'd4,
        RS_LHU = 3'd5
    } rsel_e;

    typedef enum logic [WSEL_W-1:0] {
        WS_SB = 2'd0,
        WS_SH = 2'd1,
        WS_SW = 2'd2
    } wsel_e;

    // Concatenated payload: ALU, PC+4, store data, rd, selects and the two write enables.
    function automatic int payload_width(input int dw, input int ri);
        return 3 * dw + ri + WBSEL_W + RSEL_W + WSEL_W + 2;
    endfunction

endpackage

// File: rtl/exmem_p_reg_nb.sv
// Generic N-bit enable register with synchronous active-low reset.
module p_reg_nb #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX/MEM pipeline stage with valid/ready handshake, optional skid entry,
// synchronous flush and saturating stall/flush counters.
module exmem_pipe_stage
    import exmem_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int REGINDEX  = REGINDEX_DEF,
    parameter int SKID      = 1,
    parameter int CNTW      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] alu_in,
    input  logic [DATAWIDTH-1:0] pcm_in,
    input  logic [DATAWIDTH-1:0] datareg_in,
    input  logic [REGINDEX-1:0]  rd_in,
    input  logic [WBSEL_W-1:0]   wbsel_in,
    input  logic                 memrw_in,
    input  logic [RSEL_W-1:0]    rsel_in,
    input  logic [WSEL_W-1:0]    wsel_in,
    input  logic                 regwrite_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] alu_out,
    output logic [DATAWIDTH-1:0] pcm_out,
    output logic [DATAWIDTH-1:0] datareg_out,
    output logic [REGINDEX-1:0]  rd_out,
    output logic [WBSEL_W-1:0]   wbsel_out,
    output logic                 memrw_out,
    output logic [RSEL_W-1:0]    rsel_out,
    output logic [WSEL_W-1:0]    wsel_out,
    output logic                 regwrite_out,
    output logic [CNTW-1:0]      stall_cnt,
    output logic [CNTW-1:0]      flush_cnt
);

    localparam int PW = payload_width(DATAWIDTH, REGINDEX);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic          live;
    logic          main_valid;
    logic          skid_valid;
    logic          accept;
    logic          drain;
    logic          main_load;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic          memrw_q;
    logic          regwrite_q;

    assign in_payload = {alu_in, pcm_in, datareg_in, rd_in, wbsel_in,
                         memrw_in, rsel_in, wsel_in, regwrite_in};
    assign accept     = in_valid & in_ready;
    assign drain      = main_valid & out_ready;
    assign out_valid  = main_valid;

    // live keeps in_ready low throughout reset and for the release cycle.
    generate
        if (SKID != 0) begin : g_skid
            logic          skid_load;
            logic [PW-1:0] skid_q;

            assign in_ready  = live & ~skid_valid;
            assign main_load = ~flush & (skid_valid ? drain : (accept & (~main_valid | drain)));
            assign skid_load = ~flush & ~skid_valid & accept & main_valid & ~out_ready;
            assign main_d    = skid_valid ? skid_q : in_payload;

            p_reg_nb #(.N(PW)) u_skid_reg (
                .clk (clk),
                .rst (rst),
                .en  (skid_load),
                .d   (in_payload),
                .q   (skid_q)
            );

            always_ff @(posedge clk) begin
                if (!rst)
                    skid_valid <= 1'b0;
                else if (flush)
                    skid_valid <= 1'b0;
                else if (skid_load)
                    skid_valid <= 1'b1;
                else if (drain)
                    skid_valid <= 1'b0;
            end
        end else begin : g_noskid
            assign in_ready   = live & (~main_valid | out_ready);
            assign main_load  = ~flush & accept;
            assign main_d     = in_payload;
            assign skid_valid = 1'b0;
        end
    endgenerate

    p_reg_nb #(.N(PW)) u_main_reg (
        .clk (clk),
        .rst (rst),
        .en  (main_load),
        .d   (main_d),
        .q   (main_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            live       <= 1'b0;
            main_valid <= 1'b0;
        end else begin
            live <= 1'b1;
            if (flush)
                main_valid <= 1'b0;
            else if (main_load)
                main_valid <= 1'b1;
            else if (drain)
                main_valid <= 1'b0;
        end
    end

    assign {alu_out, pcm_out, datareg_out, rd_out, wbsel_out,
            memrw_q, rsel_out, wsel_out, regwrite_q} = main_q;

    // A bubble may carry stale payload but must never write memory or the register file.
    assign memrw_out    = memrw_q & main_valid;
    assign regwrite_out = regwrite_q & main_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid & ~out_ready & (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush & (main_valid | skid_valid) & (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Self-checking bench: skid, no-skid and 4-bit-counter builds driven in parallel
// against a queue-based reference model, plus a hand-derived vector table.
module tb_exmem_pipe_stage;
    import exmem_pkg::*;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] pcm;
        logic [31:0] dat;
        logic [4:0]  rd;
        logic [1:0]  wb;
        logic        mw;
        logic [2:0]  rs;
        logic [1:0]  ws;
        logic        rw;
    } payload_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] alu;
        logic        expOv;
        logic        expIr;
        logic [31:0] expAlu;
        int          expSc;
        int          expFc;
    } vec_t;

    logic     clk = 1'b0;
    logic     rst = 1'b0;
    logic     flush = 1'b0;
    logic     in_valid = 1'b0;
    logic     out_ready = 1'b0;
    payload_t pin = '0;

    logic [31:0] alu_o [3];
    logic [31:0] pcm_o [3];
    logic [31:0] dat_o [3];
    logic [4:0]  rd_o  [3];
    logic [1:0]  wb_o  [3];
    logic [2:0]  rs_o  [3];
    logic [1:0]  ws_o  [3];
    logic        mw_o  [3];
    logic        rw_o  [3];
    logic        ov    [3];
    logic        ir    [3];
    logic [15:0] sc    [3];
    logic [15:0] fc    [3];
    logic [3:0]  scSat;
    logic [3:0]  fcSat;

    int       errors = 0;
    int       checks = 0;
    bit       checkEn = 1'b0;
    bit       live = 1'b0;
    payload_t q0[$];
    payload_t q1[$];
    int       stallM[2];
    int       flushM[2];
    vec_t     tbl[17];

    always #5 clk = ~clk;

    assign sc[2] = {12'd0, scSat};
    assign fc[2] = {12'd0, fcSat};

    exmem_pipe_stage #(.DATAWIDTH(32), .REGINDEX(5), .SKID(1), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .alu_in(pin.alu), .pcm_in(pin.pcm), .datareg_in(pin.dat), .rd_in(pin.rd),
        .wbsel_in(pin.wb), .memrw_in(pin.mw), .rsel_in(pin.rs), .wsel_in(pin.ws),
        .regwrite_in(pin.rw), .out_valid(ov[0]), .out_ready(out_ready),
        .alu_out(alu_o[0]), .pcm_out(pcm_o[0]), .datareg_out(dat_o[0]), .rd_out(rd_o[0]),
        .wbsel_out(wb_o[0]), .memrw_out(mw_o[0]), .rsel_out(rs_o[0]), .wsel_out(ws_o[0]),
        .regwrite_out(rw_o[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0])
    );

    exmem_pipe_stage #(.DATAWIDTH(32), .REGINDEX(5), .SKID(0), .CNTW(16)) dutNoSkid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .alu_in(pin.alu), .pcm_in(pin.pcm), .datareg_in(pin.dat), .rd_in(pin.rd),
        .wbsel_in(pin.wb), .memrw_in(pin.mw), .rsel_in(pin.rs), .wsel_in(pin.ws),
        .regwrite_in(pin.rw), .out_valid(ov[1]), .out_ready(out_ready),
        .alu_out(alu_o[1]), .pcm_out(pcm_o[1]), .datareg_out(dat_o[1]), .rd_out(rd_o[1]),
        .wbsel_out(wb_o[1]), .memrw_out(mw_o[1]), .rsel_out(rs_o[1]), .wsel_out(ws_o[1]),
        .regwrite_out(rw_o[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1])
    );

    exmem_pipe_stage #(.DATAWIDTH(32), .REGINDEX(5), .SKID(1), .CNTW(4)) dutSat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .alu_in(pin.alu), .pcm_in(pin.pcm), .datareg_in(pin.dat), .rd_in(pin.rd),
        .wbsel_in(pin.wb), .memrw_in(pin.mw), .rsel_in(pin.rs), .wsel_in(pin.ws),
        .regwrite_in(pin.rw), .out_valid(ov[2]), .out_ready(out_ready),
        .alu_out(alu_o[2]), .pcm_out(pcm_o[2]), .datareg_out(dat_o[2]), .rd_out(rd_o[2]),
        .wbsel_out(wb_o[2]), .memrw_out(mw_o[2]), .rsel_out(rs_o[2]), .wsel_out(ws_o[2]),
        .regwrite_out(rw_o[2]), .stall_cnt(scSat), .flush_cnt(fcSat)
    );

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic payload_t randPayload();
        payload_t p;
        p.alu = $urandom;
        p.pcm = $urandom;
        p.dat = $urandom;
        p.rd  = 5'($urandom);
        p.wb  = 2'($urandom_range(0, 2));
        p.mw  = 1'($urandom);
        p.rs  = 3'($urandom);
        p.ws  = 2'($urandom_range(0, 2));
        p.rw  = 1'($urandom);
        return p;
    endfunction

    function automatic payload_t actual(input int d);
        payload_t a;
        a = {alu_o[d], pcm_o[d], dat_o[d], rd_o[d], wb_o[d], mw_o[d], rs_o[d], ws_o[d], rw_o[d]};
        return a;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Model 0 holds up to two beats (skid build), model 1 one beat that can be replaced while draining.
    function automatic bit modelReady(input int m);
        if (!live) return 1'b0;
        if (m == 0) return q0.size() < 2;
        return (q1.size() == 0) || out_ready;
    endfunction

    task automatic modelUpdate();
        bit rdy0;
        bit rdy1;
        rdy0 = modelReady(0);
        rdy1 = modelReady(1);
        if (!rst) begin
            q0.delete();
            q1.delete();
            live = 1'b0;
            stallM = '{0, 0};
            flushM = '{0, 0};
        end else begin
            if (q0.size() > 0 && !out_ready) stallM[0]++;
            if (q1.size() > 0 && !out_ready) stallM[1]++;
            if (flush) begin
                if (q0.size() > 0) flushM[0]++;
                if (q1.size() > 0) flushM[1]++;
                q0.delete();
                q1.delete();
            end else begin
                if (q0.size() > 0 && out_ready) void'(q0.pop_front());
                if (q1.size() > 0 && out_ready) void'(q1.pop_front());
                if (in_valid && rdy0) q0.push_back(pin);
                if (in_valid && rdy1) q1.push_back(pin);
            end
            live = 1'b1;
        end
    endtask

    task automatic checkOutput();
        for (int d = 0; d < 3; d++) begin
            int m;
            int lim;
            int sz;
            payload_t e;
            m   = (d == 1) ? 1 : 0;
            lim = (d == 2) ? 15 : 65535;
            sz  = (m == 0) ? q0.size() : q1.size();
            cmp($sformatf("dut%0d out_valid", d), ov[d], sz > 0);
            cmp($sformatf("dut%0d in_ready", d), ir[d], modelReady(m));
            if (sz > 0) begin
                e = (m == 0) ? q0[0] : q1[0];
                cmp($sformatf("dut%0d payload", d), actual(d), e);
            end else begin
                cmp($sformatf("dut%0d bubble memrw", d), mw_o[d], 1'b0);
                cmp($sformatf("dut%0d bubble regwrite", d), rw_o[d], 1'b0);
            end
            cmp($sformatf("dut%0d stall_cnt", d), sc[d], sat(stallM[m], lim));
            cmp($sformatf("dut%0d flush_cnt", d), fc[d], sat(flushM[m], lim));
        end
    endtask

    task automatic applyStimulus(input logic r, input logic iv, input logic o,
                                 input logic f, input payload_t p);
        rst = r;
        in_valid = iv;
        out_ready = o;
        flush = f;
        pin = p;
        #1;
        if (checkEn) checkOutput();
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic step(input logic r, input logic iv, input logic o,
                        input logic f, input payload_t p);
        applyStimulus(r, iv, o, f, p);
        tick();
    endtask

    task automatic resetAndRelease();
        step(1'b0, 1'b1, 1'b0, 1'b0, randPayload());
        step(1'b0, 1'b1, 1'b0, 1'b1, randPayload());
        step(1'b1, 1'b0, 1'b0, 1'b0, randPayload());
    endtask

    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        payload_t p;

        tbl[0]  = '{1, 0, 0, 32'h10, 0, 1, 32'h00, 0, 0};
        tbl[1]  = '{1, 0, 0, 32'h20, 1, 1, 32'h10, 0, 0};
        tbl[2]  = '{1, 0, 0, 32'h30, 1, 0, 32'h10, 1, 0};
        tbl[3]  = '{1, 0, 0, 32'h30, 1, 0, 32'h10, 2, 0};
        tbl[4]  = '{1, 1, 0, 32'h30, 1, 0, 32'h10, 3, 0};
        tbl[5]  = '{1, 1, 0, 32'h30, 1, 1, 32'h20, 3, 0};
        tbl[6]  = '{0, 1, 0, 32'h00, 1, 1, 32'h30, 3, 0};
        tbl[7]  = '{0, 1, 0, 32'h00, 0, 1, 32'h00, 3, 0};
        tbl[8]  = '{1, 0, 0, 32'h40, 0, 1, 32'h00, 3, 0};
        tbl[9]  = '{1, 0, 0, 32'h50, 1, 1, 32'h40, 3, 0};
        tbl[10] = '{1, 0, 1, 32'h60, 1, 0, 32'h40, 4, 0};
        tbl[11] = '{1, 0, 1, 32'h70, 0, 1, 32'h00, 5, 1};
        tbl[12] = '{0, 1, 0, 32'h00, 0, 1, 32'h00, 5, 1};
        tbl[13] = '{1, 0, 0, 32'h80, 0, 1, 32'h00, 5, 1};
        tbl[14] = '{1, 1, 0, 32'h90, 1, 1, 32'h80, 5, 1};
        tbl[15] = '{1, 1, 1, 32'hA0, 1, 1, 32'h90, 5, 1};
        tbl[16] = '{0, 1, 0, 32'h00, 0, 1, 32'h00, 5, 2};

        // Reset held three cycles with EX presenting a beat.
        step(1'b0, 1'b1, 1'b0, 1'b0, randPayload());
        checkEn = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, randPayload());
        step(1'b0, 1'b1, 1'b1, 1'b0, randPayload());
        #1;
        for (int d = 0; d < 3; d++) begin
            cmp($sformatf("reset dut%0d out_valid", d), ov[d], 1'b0);
            cmp($sformatf("reset dut%0d in_ready", d), ir[d], 1'b0);
            cmp($sformatf("reset dut%0d outputs", d), actual(d), '0);
            cmp($sformatf("reset dut%0d counters", d), {sc[d], fc[d]}, '0);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, randPayload());
        cmp("release in_ready", ir[0], 1'b1);

        $display("[TB] streaming eight beats");
        for (int i = 1; i <= 8; i++) begin
            p = randPayload();
            p.alu = 32'(i);
            step(1'b1, 1'b1, 1'b1, 1'b0, p);
            cmp($sformatf("stream beat %0d alu", i), alu_o[0], 32'(i));
            cmp($sformatf("stream beat %0d valid", i), ov[0], 1'b1);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, randPayload());
        cmp("stream stall_cnt", sc[0], 16'd0);

        $display("[TB] vector table: backpressure, flush, replacement");
        resetAndRelease();
        for (int i = 0; i < 17; i++) begin
            p = randPayload();
            p.alu = tbl[i].alu;
            p.mw  = 1'b1;
            p.rw  = 1'b1;
            p.wb  = WB_MEM;
            applyStimulus(1'b1, tbl[i].iv, tbl[i].ordy, tbl[i].fl, p);
            cmp($sformatf("row%0d out_valid", i), ov[0], tbl[i].expOv);
            cmp($sformatf("row%0d in_ready", i), ir[0], tbl[i].expIr);
            if (tbl[i].expOv)
                cmp($sformatf("row%0d alu_out", i), alu_o[0], tbl[i].expAlu);
            cmp($sformatf("row%0d memrw_out", i), mw_o[0], tbl[i].expOv);
            cmp($sformatf("row%0d regwrite_out", i), rw_o[0], tbl[i].expOv);
            cmp($sformatf("row%0d stall_cnt", i), sc[0], 16'(tbl[i].expSc));
            cmp($sformatf("row%0d flush_cnt", i), fc[0], 16'(tbl[i].expFc));
            tick();
        end

        $display("[TB] stall saturation and no-skid ready path");
        resetAndRelease();
        step(1'b1, 1'b1, 1'b0, 1'b0, randPayload());
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, randPayload());
        cmp("saturated stall_cnt", scSat, 4'd15);
        cmp("wide stall_cnt", sc[0], 16'd20);
        out_ready = 1'b0;
        #1;
        cmp("noskid in_ready blocked", ir[1], 1'b0);
        out_ready = 1'b1;
        #1;
        cmp("noskid in_ready follows out_ready", ir[1], 1'b1);

        $display("[TB] randomized traffic");
        resetAndRelease();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) != 0),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 19) == 0),
                 randPayload());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
